// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//
// Purpose: lets two requesters share one external combinational ALU. A
// request is accepted in IDLE, its operands are held in local registers and
// driven to the ALU during EXEC, and the result is registered and offered on
// the owning response port in RESP until that port accepts it.
// Each operation takes at least three cycles.
//
// Configuration macro:
//   ALU_ARB_RR_EN  defined   : round-robin selection when both ports are valid
//                  undefined : fixed priority, port 0 always wins
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   r0_valid/r1_valid          per-port request valid
//   r0_ready/r1_ready          per-port request accept (IDLE only)
//   r0_op/r1_op                per-port ALU control code (1010-1111 = branch compare)
//   r0_a/r0_b/r1_a/r1_b        per-port operands
//   rsp0_valid/rsp1_valid      per-port response valid
//   rsp0_ready/rsp1_ready      per-port response accept
//   rsp_data, rsp_flag         registered result and branch-taken flag
//   alu_ctrl, alu_a, alu_b     control and operands to the shared ALU
//   alu_result, alu_flag       combinational ALU outputs
//   busy                       high whenever the FSM is not IDLE
//   owner                      port of the in-flight or last-granted request
module alu_share_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            r0_valid,
  output logic            r0_ready,
  input  logic [3:0]      r0_op,
  input  logic [XLEN-1:0] r0_a,
  input  logic [XLEN-1:0] r0_b,
  input  logic            r1_valid,
  output logic            r1_ready,
  input  logic [3:0]      r1_op,
  input  logic [XLEN-1:0] r1_a,
  input  logic [XLEN-1:0] r1_b,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_flag,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_flag,
  output logic            busy,
  output logic            owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [3:0]      op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic            sel;
  logic            handshake;
  logic            rsp_accept;
  logic            is_branch;

`ifdef ALU_ARB_RR_EN
  // Port that won the most recent grant; reset to 1 so port 0 wins the
  // first contention.
  logic last_grant;
`endif

  // Port selection. sel is only meaningful when at least one port is valid;
  // ready is qualified with valid so an idle port never sees ready.
  always_comb begin
    sel = 1'b0;
`ifdef ALU_ARB_RR_EN
    if (r0_valid && r1_valid) begin
      sel = ~last_grant;
    end else if (r1_valid) begin
      sel = 1'b1;
    end
`else
    if (!r0_valid && r1_valid) begin
      sel = 1'b1;
    end
`endif
  end

  assign handshake  = (r0_valid && r0_ready) || (r1_valid && r1_ready);
  // Only the owning port's response ready can complete RESP.
  assign rsp_accept = owner ? rsp1_ready : rsp0_ready;
  assign is_branch  = (op_q >= 4'b1010);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (handshake) state_next = EXEC;
      EXEC: state_next = RESP;
      RESP: if (rsp_accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    r0_ready   = 1'b0;
    r1_ready   = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = (state != IDLE);
    if (state == IDLE) begin
      r0_ready = r0_valid && !sel;
      r1_ready = r1_valid && sel;
    end
    if (state == RESP) begin
      rsp0_valid = !owner;
      rsp1_valid = owner;
    end
  end

  // Request capture and result registers. The ALU sees the captured
  // operands continuously; the result is taken at the end of EXEC, and the
  // flag is forced low for non-branch codes.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= 4'd0;
      a_q        <= '0;
      b_q        <= '0;
      owner      <= 1'b0;
      rsp_data   <= '0;
      rsp_flag   <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      if (state == IDLE && handshake) begin
        op_q       <= sel ? r1_op : r0_op;
        a_q        <= sel ? r1_a  : r0_a;
        b_q        <= sel ? r1_b  : r0_b;
        owner      <= sel;
`ifdef ALU_ARB_RR_EN
        last_grant <= sel;
`endif
      end
      if (state == EXEC) begin
        rsp_data <= alu_result;
        rsp_flag <= is_branch ? alu_flag : 1'b0;
      end
    end
  end

  assign alu_ctrl = op_q;
  assign alu_a    = a_q;
  assign alu_b    = b_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//
// Self-checking bench for alu_share_arbiter. A small ALU model drives
// alu_result/alu_flag from the DUT's ALU outputs. Expected responses are
// pushed to a queue when a request handshake is driven and popped when a
// response appears. Build with +define+ALU_ARB_RR_EN for the round-robin
// variant; the contention expectations follow the macro.
module tb_alu_share_arbiter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            r0_valid, r1_valid;
  logic            r0_ready, r1_ready;
  logic [3:0]      r0_op, r1_op;
  logic [XLEN-1:0] r0_a, r0_b, r1_a, r1_b;
  logic            rsp0_valid, rsp1_valid;
  logic            rsp0_ready, rsp1_ready;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_flag;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] alu_a, alu_b;
  logic [XLEN-1:0] alu_result;
  logic            alu_flag;
  logic            busy;
  logic            owner;

  typedef struct {
    logic            port;
    logic [XLEN-1:0] data;
    logic            flag;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_flag(rsp_flag),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flag(alu_flag),
    .busy(busy), .owner(owner)
  );

  // External ALU model.
  function automatic logic [XLEN-1:0] model_result(input logic [3:0] op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      default: return a - b;
    endcase
  endfunction

  // Non-branch codes return a==b so the flag is often 1 and must be masked.
  function automatic logic model_flag(input logic [3:0] op,
                                      input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
    case (op)
      4'hA:    return a == b;
      4'hB:    return a != b;
      4'hC:    return $signed(a) < $signed(b);
      4'hD:    return $signed(a) >= $signed(b);
      4'hE:    return a < b;
      4'hF:    return a >= b;
      default: return a == b;
    endcase
  endfunction

  assign alu_result = model_result(alu_ctrl, alu_a, alu_b);
  assign alu_flag   = model_flag(alu_ctrl, alu_a, alu_b);

  function automatic exp_t make_exp(input logic port, input logic [3:0] op,
                                    input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    exp_t e;
    e.port = port;
    e.data = model_result(op, a, b);
    e.flag = (op >= 4'hA) ? model_flag(op, a, b) : 1'b0;
    return e;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_op = 4'd0; r1_op = 4'd0;
    r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    compared++;
    if ({busy, owner, rsp0_valid, rsp1_valid, rsp_flag} !== 5'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000", {busy, owner, rsp0_valid, rsp1_valid, rsp_flag});
    end
    compared++;
    if (rsp_data !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_rsp_data: got %h expected 0", rsp_data);
    end
    compared++;
    if ({alu_ctrl, alu_a, alu_b} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_alu: got ctrl=%h a=%h b=%h expected all 0", alu_ctrl, alu_a, alu_b);
    end
    compared++;
    if ({r0_ready, r1_ready} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL reset_ready: got %b expected 00", {r0_ready, r1_ready});
    end
  endtask

  task automatic test_add();
    exp_t e;
    apply_reset();
    r0_op = 4'd0; r0_a = 32'd5; r0_b = 32'd7; r0_valid = 1'b1;
    #1;
    compared++;
    if ({r0_ready, r1_ready} !== 2'b10) begin
      mismatched++;
      $display("[TB] FAIL add_ready: got %b expected 10", {r0_ready, r1_ready});
    end
    exp_q.push_back(make_exp(1'b0, r0_op, r0_a, r0_b));
    @(posedge clk); @(negedge clk);
    r0_valid = 1'b0;
    #1;
    compared++;
    if ({busy, rsp0_valid, alu_a, alu_b} !== {1'b1, 1'b0, 32'd5, 32'd7}) begin
      mismatched++;
      $display("[TB] FAIL add_exec: got busy=%b rsp0_valid=%b a=%0d b=%0d expected 1 0 5 7", busy, rsp0_valid, alu_a, alu_b);
    end
    @(posedge clk); @(negedge clk);
    #1;
    compared++;
    if ({rsp0_valid, rsp1_valid, owner} !== 3'b100) begin
      mismatched++;
      $display("[TB] FAIL add_rsp_valid: got %b expected 100", {rsp0_valid, rsp1_valid, owner});
    end
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL add_scoreboard: got empty queue expected one entry");
    end else begin
      e = exp_q.pop_front();
      if (rsp_data !== e.data || rsp_data !== 32'd12 || rsp_flag !== e.flag) begin
        mismatched++;
        $display("[TB] FAIL add_result: got data=%0d flag=%b expected data=%0d flag=%b", rsp_data, rsp_flag, e.data, e.flag);
      end
    end
    @(posedge clk); @(negedge clk);
    #1;
    compared++;
    if ({busy, rsp0_valid} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL add_done: got busy/rsp0_valid=%b expected 00", {busy, rsp0_valid});
    end
  endtask

  task automatic test_contention();
    exp_t e;
    logic grant_seq[4];
    logic exp_seq[4];
    logic g;
    int   grants = 0;
    int   cyc = 0;
    bit   pend0 = 0;
    bit   pend1 = 0;
    apply_reset();
`ifdef ALU_ARB_RR_EN
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    r0_op = 4'd0; r0_a = 32'd10;  r0_b = 32'd1;
    r1_op = 4'd1; r1_a = 32'd100; r1_b = 32'd3;
    r0_valid = 1'b1; r1_valid = 1'b1;
    while ((grants < 4 || exp_q.size() != 0) && cyc < 80) begin
      if (pend0) begin r0_a = r0_a + 32'd7; pend0 = 0; end
      if (pend1) begin r1_a = r1_a + 32'd11; pend1 = 0; end
      if (grants >= 4) begin r0_valid = 1'b0; r1_valid = 1'b0; end
      #1;
      compared++;
      if (r0_ready && r1_ready) begin
        mismatched++;
        $display("[TB] FAIL contention_both_ready: got 11 expected at most one high");
      end
      if (rsp0_valid || rsp1_valid) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL contention_unexpected_rsp: got rsp %b%b expected none", rsp1_valid, rsp0_valid);
        end else begin
          e = exp_q.pop_front();
          if (rsp1_valid !== e.port || rsp0_valid !== ~e.port || rsp_data !== e.data || rsp_flag !== e.flag) begin
            mismatched++;
            $display("[TB] FAIL contention_rsp: got port=%b data=%0d flag=%b expected port=%b data=%0d flag=%b",
                     rsp1_valid, rsp_data, rsp_flag, e.port, e.data, e.flag);
          end
        end
      end
      if (grants < 4 && (r0_ready || r1_ready)) begin
        g = r1_ready;
        grant_seq[grants] = g;
        if (g) begin
          exp_q.push_back(make_exp(1'b1, r1_op, r1_a, r1_b));
          pend1 = 1;
        end else begin
          exp_q.push_back(make_exp(1'b0, r0_op, r0_a, r0_b));
          pend0 = 1;
        end
        grants++;
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    compared++;
    if (cyc >= 80) begin
      mismatched++;
      $display("[TB] FAIL contention_timeout: got %0d grants expected 4 within 80 cycles", grants);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < grants) begin
        compared++;
        if (grant_seq[i] !== exp_seq[i]) begin
          mismatched++;
          $display("[TB] FAIL contention_grant%0d: got port %b expected port %b", i, grant_seq[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_branch();
    exp_t e;
    apply_reset();
    r1_op = 4'hA; r1_a = 32'd3; r1_b = 32'd3; r1_valid = 1'b1;
    #1;
    compared++;
    if ({r0_ready, r1_ready} !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL branch_ready: got %b expected 01", {r0_ready, r1_ready});
    end
    exp_q.push_back(make_exp(1'b1, r1_op, r1_a, r1_b));
    @(posedge clk); @(negedge clk);
    r1_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    #1;
    compared++;
    if ({rsp0_valid, rsp1_valid, owner} !== 3'b011) begin
      mismatched++;
      $display("[TB] FAIL branch_rsp_valid: got %b expected 011", {rsp0_valid, rsp1_valid, owner});
    end
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL branch_scoreboard: got empty queue expected one entry");
    end else begin
      e = exp_q.pop_front();
      if (rsp_flag !== 1'b1 || rsp_flag !== e.flag || rsp_data !== e.data) begin
        mismatched++;
        $display("[TB] FAIL branch_result: got data=%0d flag=%b expected data=%0d flag=1", rsp_data, rsp_flag, e.data);
      end
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_backpressure();
    exp_t e;
    apply_reset();
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    r0_op = 4'd1; r0_a = 32'd20; r0_b = 32'd8; r0_valid = 1'b1;
    #1;
    compared++;
    if (r0_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL bp_r0_ready: got %b expected 1", r0_ready);
    end
    exp_q.push_back(make_exp(1'b0, r0_op, r0_a, r0_b));
    @(posedge clk); @(negedge clk);
    r0_valid = 1'b0;
    r1_op = 4'd2; r1_a = 32'h0000_F0F0; r1_b = 32'h0000_FF00; r1_valid = 1'b1;
    #1;
    compared++;
    if (r1_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL bp_exec_r1_ready: got %b expected 0", r1_ready);
    end
    @(posedge clk); @(negedge clk);
    e = exp_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      #1;
      compared++;
      if ({rsp0_valid, rsp1_valid, r1_ready, busy} !== 4'b1001 || rsp_data !== e.data || rsp_flag !== e.flag) begin
        mismatched++;
        $display("[TB] FAIL bp_hold%0d: got v0/v1/r1rdy/busy=%b data=%0d expected 1001 data=%0d",
                 i, {rsp0_valid, rsp1_valid, r1_ready, busy}, rsp_data, e.data);
      end
      @(posedge clk); @(negedge clk);
    end
    rsp0_ready = 1'b1;
    #1;
    compared++;
    if (r1_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL bp_accept_cycle_r1_ready: got %b expected 0", r1_ready);
    end
    @(posedge clk); @(negedge clk);
    #1;
    compared++;
    if ({r1_ready, busy, rsp0_valid} !== 3'b100) begin
      mismatched++;
      $display("[TB] FAIL bp_regrant: got r1rdy/busy/v0=%b expected 100", {r1_ready, busy, rsp0_valid});
    end
    exp_q.push_back(make_exp(1'b1, r1_op, r1_a, r1_b));
    @(posedge clk); @(negedge clk);
    r1_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    #1;
    compared++;
    e = exp_q.pop_front();
    if (rsp1_valid !== 1'b1 || rsp_data !== e.data || owner !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL bp_r1_rsp: got v1=%b data=%h owner=%b expected 1 %h 1", rsp1_valid, rsp_data, owner, e.data);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    r0_op = 4'd0; r0_a = 32'd1; r0_b = 32'd2; r0_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    r0_valid = 1'b0;
    #1;
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rstmid_exec_busy: got %b expected 1", busy);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    compared++;
    if ({busy, rsp0_valid, rsp1_valid} !== 3'b000 || rsp_data !== '0) begin
      mismatched++;
      $display("[TB] FAIL rstmid_after: got busy/v0/v1=%b data=%0d expected 000 data=0", {busy, rsp0_valid, rsp1_valid}, rsp_data);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      #1;
      compared++;
      if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
        mismatched++;
        $display("[TB] FAIL rstmid_quiet%0d: got v0/v1/busy=%b expected 000", i, {rsp0_valid, rsp1_valid, busy});
      end
    end
  endtask

  task automatic test_flag_masking();
    exp_t e;
    logic [3:0]      ops[2];
    logic [XLEN-1:0] as[2];
    logic [XLEN-1:0] bs[2];
    logic            fl[2];
    ops = '{4'h5, 4'hF};
    as  = '{32'd9, 32'd3};
    bs  = '{32'd9, 32'd2};
    fl  = '{1'b0, 1'b1};
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      r0_op = ops[i]; r0_a = as[i]; r0_b = bs[i]; r0_valid = 1'b1;
      exp_q.push_back(make_exp(1'b0, r0_op, r0_a, r0_b));
      @(posedge clk); @(negedge clk);
      r0_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      #1;
      compared++;
      e = exp_q.pop_front();
      if (rsp0_valid !== 1'b1 || rsp_flag !== fl[i] || rsp_flag !== e.flag || rsp_data !== e.data) begin
        mismatched++;
        $display("[TB] FAIL flag_op%h: got v0=%b flag=%b data=%0d expected 1 flag=%b data=%0d",
                 ops[i], rsp0_valid, rsp_flag, rsp_data, fl[i], e.data);
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_op = 4'd0; r1_op = 4'd0;
    r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    test_reset();
    test_add();
    test_contention();
    test_branch();
    test_backpressure();
    test_reset_mid();
    test_flag_masking();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
